ahb_lite_bram_slave: RTL
========================

AHB_LITE_BRAM_SLAVE -- requirements
Module: ahb_lite_bram_slave

Interface
REQ-001 SHALL have parameter W_ADDR, default 32: AHB address width.
REQ-002 SHALL have parameter W_DATA, default 32: AHB data width, fixed at 32 because byte-lane logic is 4 lanes.
REQ-003 SHALL have parameter AW, default 10: BRAM word-address width; depth is 2^AW words.
REQ-004 SHALL have port HCLK  in  1  clock; the single clock, all state on its rising edge.
REQ-005 SHALL have port HRESET  in  1  reset; asynchronous and active-high.
REQ-006 SHALL have port HSEL  in  1  slave select from the decoder.
REQ-007 SHALL have port HREADY  in  1  bus ready; an address phase is sampled only when this is 1.
REQ-008 SHALL have ports HTRANS  in  2, HSIZE  in  3, HADDR  in  W_ADDR, HWRITE  in  1: address-phase controls.
REQ-009 SHALL have port HWDATA  in  W_DATA  write data, valid in the data phase.
REQ-010 SHALL have ports HREADYOUT  out  1, HRESP  out  2 (OKAY=0, ERROR=1), HRDATA  out  W_DATA.
REQ-011 SHALL have ports bram_en  out  1, bram_we  out  4, bram_addr  out  AW, bram_wdata  out  W_DATA, bram_rdata  in  W_DATA: single-port BRAM with 1-cycle read latency.
REQ-012 SHALL have port q_state  out  3  current FSM state, for debugging.

Function
REQ-013 SHALL accept a transfer when HSEL && HREADY && HTRANS is NONSEQ or SEQ; IDLE and BUSY are no-transfer; HSEL=0 is always no-transfer.
REQ-014 SHALL register HADDR, HWRITE and HSIZE on acceptance; the data phase uses only the registered values.
REQ-015 SHALL implement states ST_IDLE=0, ST_WRITE=1, ST_RD_ISSUE=2, ST_RD_DATA=3, ST_ERR1=4, ST_ERR2=5.
REQ-016 SHALL, in ST_IDLE, ST_WRITE, ST_RD_DATA and ST_ERR2 (the "ready states"), drive HREADYOUT=1 and select the next state from the current address phase: error transfer -> ST_ERR1; write -> ST_WRITE; read -> ST_RD_ISSUE; no transfer -> ST_IDLE.
REQ-017 SHALL, in ST_WRITE, drive bram_en=1, bram_we=lane mask, bram_addr=q_addr[AW+1:2], bram_wdata=HWDATA and HRESP=OKAY; writes complete with zero wait states.
REQ-018 SHALL, in ST_RD_ISSUE, drive bram_en=1, bram_we=0, bram_addr=q_addr[AW+1:2], HREADYOUT=0, then go unconditionally to ST_RD_DATA.
REQ-019 SHALL, in ST_RD_DATA, drive HRDATA=bram_rdata (full word, all lanes) and HREADYOUT=1; reads therefore take exactly one wait state.
REQ-020 SHALL drive HRDATA=0 in every state except ST_RD_DATA.
REQ-021 SHALL drive bram_en=0 and bram_we=0 in every state except ST_WRITE and ST_RD_ISSUE.
REQ-022 SHALL use little-endian lane masks: byte -> 4'b0001<<addr[1:0]; halfword -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111.
REQ-023 SHALL, in ST_ERR1, drive HREADYOUT=0 and HRESP=ERROR, then go to ST_ERR2; in ST_ERR2, drive HREADYOUT=1 and HRESP=ERROR.
REQ-024 SHALL ignore HTRANS in ST_ERR1 and ST_RD_ISSUE, since HREADY is low in those states.
REQ-025 SHALL, on a read directly after a write to the same word, return the written data; BRAM write-first ordering plus the ST_RD_ISSUE cycle guarantees this.
REQ-026 SHALL drive HRESP=OKAY in all states other than ST_ERR1 and ST_ERR2.

Reset
REQ-027 SHALL, with HRESET=1, immediately force ST_IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, bram_en=0, bram_we=0, registered address, HWRITE and HSIZE to 0, and q_state=0.
REQ-028 SHALL abandon an in-progress transfer on reset mid-operation; no BRAM write is issued after reset asserts.

Configuration
REQ-029 SHALL use macro AHB_BRAM_ERR_RESP_EN to select error handling.
REQ-030 SHALL, with AHB_BRAM_ERR_RESP_EN defined, treat any of the following as an error transfer: HSIZE>2; misalignment (halfword with addr[0]=1, or word with addr[1:0]!=0); or HADDR[W_ADDR-1:AW+2]!=0.
REQ-031 SHALL, without AHB_BRAM_ERR_RESP_EN, never enter ST_ERR1 or ST_ERR2: upper address bits are ignored (wrap-around), HSIZE>2 is treated as word, and misaligned low bits are ignored for halfword and word.

Verification
REQ-032 SHALL cover: word write 0x004 data 0xDEADBEEF, then read 0x004 -> write 0 wait states, bram_we=1111; read has 1 wait state and HRDATA=0xDEADBEEF.
REQ-033 SHALL cover: byte write 0x013 data 0xAA000000, then word read 0x010 -> bram_we=1000, byte lane 3 of HRDATA=0xAA.
REQ-034 SHALL cover: back-to-back NONSEQ write 0x020 then read 0x020 -> ST_WRITE, ST_RD_ISSUE, ST_RD_DATA; read returns the new data.
REQ-035 SHALL cover: with macro defined, word read at 0x002 -> HREADYOUT 0 then 1, HRESP=ERROR for both cycles, bram_en stays 0; without the macro -> OKAY, and data from word 0 is returned.
REQ-036 SHALL cover: HTRANS=BUSY, or HSEL=0 with NONSEQ -> state stays ST_IDLE, bram_en=0.
REQ-037 SHALL cover: HRESET asserted during ST_RD_ISSUE -> same-cycle q_state=0, bram_en=0, HREADYOUT=1.

Source files
------------

// File: rtl/ahb_lite_bram_slave_if.sv
// AHB-Lite bus bundle between one master/interconnect and the BRAM slave.
// Signals: HSEL HREADY HTRANS HSIZE HADDR HWRITE HWDATA / HREADYOUT HRESP HRDATA.
interface ahb_lite_bram_slave_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              HSEL;
  logic              HREADY;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [W_ADDR-1:0] HADDR;
  logic              HWRITE;
  logic [W_DATA-1:0] HWDATA;
  logic              HREADYOUT;
  logic [1:0]        HRESP;
  logic [W_DATA-1:0] HRDATA;

  modport master (
    output HSEL, HREADY, HTRANS, HSIZE,
    output HADDR, HWRITE, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HTRANS, HSIZE,
    input  HADDR, HWRITE, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_bram_slave.sv
// AHB-Lite slave in front of a 1-cycle-latency single-port BRAM.
// Ports: HCLK, HRESET (async, active-high), bus (AHB slave modport),
//   bram_en/we/addr/wdata/rdata (BRAM side), q_state (debug FSM state).
// Writes: zero wait states. Reads: one wait state (issue, then data).
// Macro AHB_BRAM_ERR_RESP_EN: when defined, oversize, misaligned or
//   out-of-range transfers get a two-cycle ERROR response; when not,
//   the address wraps, HSIZE>2 acts as word and low bits are ignored.
module ahb_lite_bram_slave #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int AW     = 10
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_lite_bram_slave_if.slave bus,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [AW-1:0]     bram_addr,
  output logic [W_DATA-1:0] bram_wdata,
  input  logic [W_DATA-1:0] bram_rdata,
  output logic [2:0]        q_state
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WRITE    = 3'd1;
  localparam logic [2:0] ST_RD_ISSUE = 3'd2;
  localparam logic [2:0] ST_RD_DATA  = 3'd3;
  localparam logic [2:0] ST_ERR1     = 3'd4;
  localparam logic [2:0] ST_ERR2     = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [AW+1:0] q_addr;
  logic          q_write;
  logic [2:0]    q_size;
  logic          xfer;
  logic          err_xfer;
  logic          ready_st;
  logic [3:0]    lane_mask;
  logic          unused_bits;

  // HTRANS[1] set means NONSEQ or SEQ
  assign xfer = bus.HSEL && bus.HREADY && bus.HTRANS[1];

`ifdef AHB_BRAM_ERR_RESP_EN
  assign err_xfer = xfer && (
      (bus.HSIZE > 3'd2)
   || (bus.HSIZE == 3'd1 && bus.HADDR[0])
   || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)
   || (bus.HADDR[W_ADDR-1:AW+2] != '0));
`else
  assign err_xfer = 1'b0;
`endif

  // Upper address bits only matter to the error check
  assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[W_ADDR-1:AW+2]};

  assign ready_st = (state == ST_IDLE)    || (state == ST_WRITE)
                 || (state == ST_RD_DATA) || (state == ST_ERR2);

  always_comb begin
    state_nx = ST_IDLE;
    unique case (state)
      ST_IDLE, ST_WRITE, ST_RD_DATA, ST_ERR2: begin
        if (err_xfer)        state_nx = ST_ERR1;
        else if (!xfer)      state_nx = ST_IDLE;
        else if (bus.HWRITE) state_nx = ST_WRITE;
        else                 state_nx = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: state_nx = ST_RD_DATA;
      ST_ERR1:     state_nx = ST_ERR2;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      q_addr  <= '0;
      q_write <= 1'b0;
      q_size  <= 3'd0;
    end else begin
      state <= state_nx;
      if (ready_st && xfer) begin
        q_addr  <= bus.HADDR[AW+1:0];
        q_write <= bus.HWRITE;
        q_size  <= bus.HSIZE;
      end
    end
  end

  // Little-endian lanes; sizes above word behave as word
  always_comb begin
    lane_mask = 4'b1111;
    unique case (q_size)
      3'd0:    lane_mask = 4'b0001 << q_addr[1:0];
      3'd1:    lane_mask = q_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 2'd0;
    bus.HRDATA    = '0;
    bram_en       = 1'b0;
    bram_we       = 4'b0000;
    bram_addr     = q_addr[AW+1:2];
    bram_wdata    = '0;
    unique case (state)
      ST_WRITE: begin
        bram_en    = q_write;
        bram_we    = lane_mask;
        bram_wdata = bus.HWDATA;
      end
      ST_RD_ISSUE: begin
        bram_en       = 1'b1;
        bus.HREADYOUT = 1'b0;
      end
      ST_RD_DATA: bus.HRDATA = bram_rdata;
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 2'd1;
      end
      ST_ERR2: bus.HRESP = 2'd1;
      default: ;
    endcase
  end

  assign q_state = state;

endmodule
